// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_arbiter
//  Purpose  : Round-robin arbiter that lets two requesters share one
//             WIDTH-bit ripple add/sub datapath. Only one operation is in
//             flight at a time. Requests and the response use valid/ready.
//  Ports    : clk_i, rst_i                  clock / sync active-high reset
//             req{0,1}_valid_i/_ready_o     request handshake
//             req{0,1}_a_i, _b_i, _mode_i   operands, mode 0=A+B 1=A-B
//             rsp_valid_o / rsp_ready_i     response handshake
//             rsp_result_o, rsp_id_o,       result mod 2^WIDTH, requester id,
//             rsp_ovf_o                     signed overflow flag
//  Revision : 1.0  initial release
// ============================================================================
module addsub_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req0_mode_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic             req1_mode_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_id_o,
  output logic             rsp_ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             r_id;
  logic             r_mode;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_id;
  logic             r_rsp_ovf;

  logic             w_accept;
  logic             w_grant_id;
  logic [WIDTH-1:0] w_bmux;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  // Shared add/sub datapath: subtraction is A + ~B + 1.
  assign w_bmux = r_b ^ {WIDTH{r_mode}};
  assign w_sum  = r_a + w_bmux + {{(WIDTH-1){1'b0}}, r_mode};
  assign w_ovf  = (r_a[WIDTH-1] == w_bmux[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

  // Grant selection and next state. Ready is held low while reset is
  // asserted so no request is consumed by a cycle that reset discards.
  always_comb begin
    w_state_nxt  = r_state;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    w_accept     = 1'b0;
    w_grant_id   = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      w_grant_id = ~r_last_grant;
    end else if (req1_valid_i) begin
      w_grant_id = 1'b1;
    end
    case (r_state)
      ST_IDLE: begin
        if (!rst_i && (req0_valid_i || req1_valid_i)) begin
          w_accept     = 1'b1;
          req0_ready_o = ~w_grant_id;
          req1_ready_o = w_grant_id;
          w_state_nxt  = ST_CALC;
        end
      end
      ST_CALC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_mode       <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_mode       <= w_grant_id ? req1_mode_i : req0_mode_i;
            r_a          <= w_grant_id ? req1_a_i    : req0_a_i;
            r_b          <= w_grant_id ? req1_b_i    : req0_b_i;
          end
        end
        ST_CALC: begin
          r_rsp_result <= w_sum;
          r_rsp_id     <= r_id;
          r_rsp_ovf    <= w_ovf;
          r_rsp_valid  <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_result_o = r_rsp_result;
  assign rsp_id_o     = r_rsp_id;
  assign rsp_ovf_o    = r_rsp_ovf;

endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addsub_arbiter
//  Purpose  : Self-checking bench for addsub_arbiter. A negedge monitor pushes
//             an expected response for every accepted request and pops /
//             compares it on every response handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_addsub_arbiter;

  localparam int WIDTH = 5;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             id;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             req0_valid_i = 1'b0;
  logic             req0_ready_o;
  logic [WIDTH-1:0] req0_a_i = '0;
  logic [WIDTH-1:0] req0_b_i = '0;
  logic             req0_mode_i = 1'b0;
  logic             req1_valid_i = 1'b0;
  logic             req1_ready_o;
  logic [WIDTH-1:0] req1_a_i = '0;
  logic [WIDTH-1:0] req1_b_i = '0;
  logic             req1_mode_i = 1'b0;
  logic             rsp_valid_o;
  logic             rsp_ready_i = 1'b1;
  logic [WIDTH-1:0] rsp_result_o;
  logic             rsp_id_o;
  logic             rsp_ovf_o;

  addsub_arbiter #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req0_mode_i  (req0_mode_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .req1_mode_i  (req1_mode_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_id_o     (rsp_id_o),
    .rsp_ovf_o    (rsp_ovf_o)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t sb[$];
  int   grant_q[$];
  bit   acc_flag = 0;
  bit   rsp_flag = 0;
  bit   prev_valid = 0;
  bit   prev_rready = 0;
  exp_t prev_rsp;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: signed integer arithmetic, overflow = out of range.
  function automatic exp_t model(input logic id, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic mode);
    exp_t e;
    int   sa;
    int   sbv;
    int   s;
    sa    = $signed(a);
    sbv   = $signed(b);
    s     = mode ? (sa - sbv) : (sa + sbv);
    e.res = s[WIDTH-1:0];
    e.id  = id;
    e.ovf = (s > 15) || (s < -16);
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    exp_t cur;
    cur = '{res: rsp_result_o, id: rsp_id_o, ovf: rsp_ovf_o};
    if (rst_i) begin
      sb.delete();
      prev_valid  = 0;
      prev_rready = 0;
      return;
    end
    if (req0_ready_o && req1_ready_o) chk("ready_excl", 1, 0);
    if (req0_valid_i && req0_ready_o) begin
      sb.push_back(model(1'b0, req0_a_i, req0_b_i, req0_mode_i));
      grant_q.push_back(0);
      acc_cyc = cyc; acc_flag = 1;
    end
    if (req1_valid_i && req1_ready_o) begin
      sb.push_back(model(1'b1, req1_a_i, req1_b_i, req1_mode_i));
      grant_q.push_back(1);
      acc_cyc = cyc; acc_flag = 1;
    end
    if (rsp_valid_o && !prev_valid) chk("latency", cyc - acc_cyc, 2);
    if (rsp_valid_o && prev_valid && !prev_rready) begin
      chk("stall_result", cur.res, prev_rsp.res);
      chk("stall_id", cur.id, prev_rsp.id);
      chk("stall_ovf", cur.ovf, prev_rsp.ovf);
      chk("stall_ready", {req0_ready_o, req1_ready_o}, 0);
    end
    if (rsp_valid_o && rsp_ready_i) begin
      rsp_flag = 1;
      if (sb.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_result", cur.res, e.res);
        chk("rsp_id", cur.id, e.id);
        chk("rsp_ovf", cur.ovf, e.ovf);
      end
    end
    prev_valid  = rsp_valid_o;
    prev_rready = rsp_ready_i;
    prev_rsp    = cur;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc();
    int n = 0;
    while (!acc_flag && n < 20) begin cycle(); n++; end
    chk("acc_timeout", acc_flag, 1);
    acc_flag = 0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_flag && n < 20) begin cycle(); n++; end
    chk("rsp_timeout", rsp_flag, 1);
    rsp_flag = 0;
  endtask

  task automatic do_op(input logic id, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic mode);
    acc_flag = 0; rsp_flag = 0;
    if (id) begin
      req1_a_i = a; req1_b_i = b; req1_mode_i = mode; req1_valid_i = 1'b1;
    end else begin
      req0_a_i = a; req0_b_i = b; req0_mode_i = mode; req0_valid_i = 1'b1;
    end
    wait_acc();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    wait_rsp();
  endtask

  initial begin
    // Reset with both requesters asserting: nothing may be accepted.
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b1;
    repeat (3) cycle();
    chk("rst_valid", rsp_valid_o, 0);
    chk("rst_result", rsp_result_o, 0);
    chk("rst_id", rsp_id_o, 0);
    chk("rst_ovf", rsp_ovf_o, 0);
    chk("rst_ready", {req0_ready_o, req1_ready_o}, 0);
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    rst_i = 1'b0;
    cycle();

    // Directed operations, including wrap-around and overflow corners.
    do_op(1'b0, 5'd3,  5'd4, 1'b0);
    do_op(1'b1, 5'd5,  5'd9, 1'b1);
    do_op(1'b1, 5'h10, 5'd1, 1'b1);
    do_op(1'b0, 5'd15, 5'd1, 1'b0);
    do_op(1'b0, 5'd31, 5'd1, 1'b0);
    do_op(1'b1, 5'd12, 5'd7, 1'b0);

    // Backpressure: hold the response for 5 cycles while req1 waits.
    rsp_ready_i = 1'b0;
    acc_flag = 0; rsp_flag = 0;
    req0_a_i = 5'd20; req0_b_i = 5'd25; req0_mode_i = 1'b1; req0_valid_i = 1'b1;
    wait_acc();
    req0_valid_i = 1'b0;
    req1_a_i = 5'd9; req1_b_i = 5'd9; req1_mode_i = 1'b0; req1_valid_i = 1'b1;
    begin
      int n = 0;
      while (!rsp_valid_o && n < 10) begin cycle(); n++; end
    end
    chk("stall_valid", rsp_valid_o, 1);
    repeat (5) cycle();
    chk("stall_held", rsp_valid_o, 1);
    rsp_ready_i = 1'b1;
    cycle();
    chk("stall_done", rsp_flag, 1);
    rsp_flag = 0;
    chk("stall_drop", rsp_valid_o, 0);
    wait_acc();
    req1_valid_i = 1'b0;
    wait_rsp();

    // Round-robin after a fresh reset: both valid continuously.
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    grant_q.delete();
    req0_a_i = 5'd1; req0_b_i = 5'd2;  req0_mode_i = 1'b0; req0_valid_i = 1'b1;
    req1_a_i = 5'd7; req1_b_i = 5'd11; req1_mode_i = 1'b1; req1_valid_i = 1'b1;
    begin
      int n = 0;
      while (grant_q.size() < 4 && n < 30) begin cycle(); n++; end
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    chk("rr_count", grant_q.size(), 4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
      chk($sformatf("rr_order%0d", i), grant_q[i], i % 2);
    end
    begin
      int n = 0;
      while ((sb.size() != 0 || rsp_valid_o) && n < 20) begin cycle(); n++; end
    end
    chk("rr_drain", sb.size(), 0);

    // Reset while an operation is in CALC.
    acc_flag = 0; rsp_flag = 0;
    req0_a_i = 5'd6; req0_b_i = 5'd6; req0_mode_i = 1'b0; req0_valid_i = 1'b1;
    wait_acc();
    req0_valid_i = 1'b0;
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    chk("midrst_valid", rsp_valid_o, 0);
    chk("midrst_result", rsp_result_o, 0);
    req0_valid_i = 1'b1;
    req1_valid_i = 1'b1;
    #1;
    chk("midrst_grant0", req0_ready_o, 1);
    chk("midrst_grant1", req1_ready_o, 0);
    wait_acc();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    wait_rsp();
    chk("final_sb", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
